uart_rx: RTL and testbench

- Asynchronous serial receiver: 1 start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 stop bit.
- The line is oversampled at the system clock; `prescale` clocks make up one bit period.
- It sits behind the serial input pin. For each good frame it presents the parallel word with a single-cycle valid strobe.

---
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver.
// Frame is 1 start bit, DATA_WIDTH data bits LSB first, an optional parity
// bit and 1 stop bit. Each bit is the majority of three samples taken around
// mid-bit. A good frame updates p_data and pulses data_valid for one clock.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_data,
  input  logic                      parity_type,
  input  logic                      parity_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [DATA_WIDTH-1:0]     p_data,
  output logic                      data_valid
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q;
  state_t                    res_st_q;   // state the pending samples belong to
  logic                      s_meta_q, s_sync_q;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      par_en_q, par_type_q;
  logic [BW-1:0]             bit_cnt_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      smp0_q, smp1_q, smp2_q;
  logic                      res_q;      // majority is resolved this cycle
  logic                      perr_q;
  logic [DATA_WIDTH-1:0]     p_data_q;
  logic                      valid_q;

  logic [PRESCALE_WIDTH-1:0] half_w, smp_lo_w, smp_hi_w, last_w;
  logic                      end_bit_w, maj_w, exp_par_w;

  assign half_w    = presc_q >> 1;
  assign smp_lo_w  = half_w - 1'b1;
  assign smp_hi_w  = half_w + 1'b1;
  assign last_w    = presc_q - 1'b1;
  assign end_bit_w = (edge_cnt_q == last_w);
  assign maj_w     = (smp0_q & smp1_q) | (smp0_q & smp2_q) | (smp1_q & smp2_q);
  assign exp_par_w = par_type_q ? ~^shift_q : ^shift_q;

  assign p_data     = p_data_q;
  assign data_valid = valid_q;

  // Two-flop synchronizer on the serial line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta_q <= 1'b1;
      s_sync_q <= 1'b1;
    end else begin
      s_meta_q <= s_data;
      s_sync_q <= s_meta_q;
    end
  end

  // Frame FSM: bit timing, 3-point sampling, majority resolve and output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      res_st_q   <= IDLE;
      edge_cnt_q <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      smp2_q     <= 1'b1;
      res_q      <= 1'b0;
      perr_q     <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      res_q   <= 1'b0;
      if (state_q == IDLE) begin
        edge_cnt_q <= '0;
        if (!s_sync_q) begin
          // The detect cycle is edge 0 of the start bit. The low level is
          // recorded as the first sample in case P/2-1 lands on edge 0.
          state_q    <= START;
          edge_cnt_q <= PRESCALE_WIDTH'(1);
          presc_q    <= prescale;
          par_en_q   <= parity_en;
          par_type_q <= parity_type;
          bit_cnt_q  <= '0;
          perr_q     <= 1'b0;
          smp0_q     <= 1'b0;
        end
      end else begin
        edge_cnt_q <= end_bit_w ? '0 : edge_cnt_q + 1'b1;

        if (edge_cnt_q == smp_lo_w) smp0_q <= s_sync_q;
        if (edge_cnt_q == half_w)   smp1_q <= s_sync_q;
        if (edge_cnt_q == smp_hi_w) begin
          smp2_q   <= s_sync_q;
          res_q    <= 1'b1;
          res_st_q <= state_q;
        end

        // Bit-boundary transitions; STOP leaves only on its resolve.
        if (end_bit_w) begin
          case (state_q)
            START: begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
            DATA: begin
              if (bit_cnt_q == BW'(DATA_WIDTH - 1))
                state_q <= par_en_q ? PARITY : STOP;
              else
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            PARITY:  state_q <= STOP;
            default: ;
          endcase
        end

        // Resolve comes last so a glitch or stop exit overrides a boundary
        // transition that falls on the same cycle (small prescale values).
        if (res_q) begin
          case (res_st_q)
            START:  if (maj_w) state_q <= IDLE;
            DATA:   shift_q <= {maj_w, shift_q[DATA_WIDTH-1:1]};
            PARITY: if (maj_w != exp_par_w) perr_q <= 1'b1;
            STOP: begin
              state_q <= IDLE;
              if (maj_w && !perr_q) begin
                p_data_q <= shift_q;
                valid_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: table of single frames plus hand-written
// sequences for reset, glitch, back-to-back, config change and mid-frame reset.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_data;
  logic       parity_type;
  logic       parity_en;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .parity_type(parity_type),
    .parity_en(parity_en), .prescale(prescale), .p_data(p_data),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         pulses = 0;
  logic [7:0] got [$];

  // Count high cycles of data_valid, so a stretched pulse counts as more.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      pulses++;
      got.push_back(p_data);
    end
  end

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         send_par;
    bit         par_bit;
    bit         stop;
    int         exp_n;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int p);
    s_data = b;
    tick(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit send_par,
                            input bit par_bit, input bit stop);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (send_par) send_bit(par_bit, p);
    send_bit(stop, p);
    s_data = 1'b1;
  endtask

  initial begin
    //          p  pe pt data   sp pb st  n  p_data
    vecs[0]  = '{8,  0, 0, 8'h55, 0, 0, 1, 1, 8'h55}; // no parity
    vecs[1]  = '{8,  1, 1, 8'hAA, 1, 1, 1, 1, 8'hAA}; // odd, good parity
    vecs[2]  = '{8,  1, 0, 8'h55, 1, 0, 1, 1, 8'h55}; // even, good parity
    vecs[3]  = '{8,  1, 1, 8'h55, 1, 0, 1, 0, 8'h55}; // odd, bad parity
    vecs[4]  = '{8,  0, 0, 8'hF0, 0, 0, 0, 0, 8'h55}; // framing error
    vecs[5]  = '{4,  0, 0, 8'h81, 0, 0, 1, 1, 8'h81}; // minimum prescale
    vecs[6]  = '{5,  1, 0, 8'h07, 1, 1, 1, 1, 8'h07}; // odd prescale, even parity
    vecs[7]  = '{8,  1, 1, 8'h3C, 1, 1, 0, 0, 8'h07}; // parity ok, stop low
    vecs[8]  = '{63, 0, 0, 8'hA5, 0, 0, 1, 1, 8'hA5}; // maximum prescale
    vecs[9]  = '{8,  1, 0, 8'h01, 0, 0, 1, 1, 8'h01}; // stop taken as parity, matches
    vecs[10] = '{8,  1, 0, 8'h03, 0, 0, 1, 0, 8'h01}; // stop taken as parity, mismatch

    rst = 1'b1; s_data = 1'b1; parity_type = 1'b0; parity_en = 1'b0;
    prescale = 6'd8;
    tick(2);
    check("reset_p_data", p_data, 8'h00);
    check("reset_valid", data_valid, 0);
    rst = 1'b0;
    tick(200);
    check("reset_idle_pulses", pulses, 0);
    check("reset_idle_p_data", p_data, 8'h00);

    // Table of single frames, each followed by an idle gap.
    for (int v = 0; v < 11; v++) begin
      pulses = 0;
      prescale    = 6'(vecs[v].p);
      parity_en   = vecs[v].pe;
      parity_type = vecs[v].pt;
      send_frame(vecs[v].data, vecs[v].p, vecs[v].send_par, vecs[v].par_bit, vecs[v].stop);
      tick(3 * vecs[v].p + 4);
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_n);
      check($sformatf("vec%0d_p_data", v), p_data, vecs[v].exp_pd);
    end

    // Start-bit glitch of P/2-2 clocks, then a good frame proves IDLE recovery.
    prescale = 6'd8; parity_en = 1'b0; pulses = 0;
    s_data = 1'b0; tick(2); s_data = 1'b1; tick(30);
    check("glitch_pulses", pulses, 0);
    check("glitch_p_data", p_data, 8'h01);
    send_frame(8'h5A, 8, 0, 0, 1);
    tick(28);
    check("after_glitch_pulses", pulses, 1);
    check("after_glitch_p_data", p_data, 8'h5A);

    // Back-to-back frames with no idle gap.
    prescale = 6'd16; pulses = 0; got.delete();
    send_frame(8'h3C, 16, 0, 0, 1);
    send_frame(8'hC3, 16, 0, 0, 1);
    tick(50);
    check("b2b_pulses", pulses, 2);
    if (got.size() == 2) begin
      check("b2b_first", got[0], 8'h3C);
      check("b2b_second", got[1], 8'hC3);
    end else begin
      check("b2b_count", got.size(), 2);
    end

    // Prescale changed mid-frame only affects the next frame.
    prescale = 6'd8; pulses = 0;
    send_bit(1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      send_bit(logic'((8'h96 >> i) & 1), 8);
      if (i == 2) prescale = 6'd16;
    end
    send_bit(1'b1, 8);
    tick(30);
    check("cfg_change_pulses", pulses, 1);
    check("cfg_change_p_data", p_data, 8'h96);

    // Next frame uses the new prescale of 16.
    pulses = 0;
    send_frame(8'h69, 16, 0, 0, 1);
    tick(50);
    check("new_prescale_pulses", pulses, 1);
    check("new_prescale_p_data", p_data, 8'h69);

    // Reset mid-frame aborts it; the rest of the line stays high.
    prescale = 6'd8; pulses = 0;
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b1, 4);
    rst = 1'b1; tick(1); rst = 1'b0;
    send_bit(1'b1, 100);
    check("midreset_pulses", pulses, 0);
    check("midreset_p_data", p_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
